// File: rtl/adc_frame_scheduler_if.sv
// ADC-side request/done handshake and frame FIFO output port of adc_frame_scheduler.
// The scheduler uses the master modport; the ADC controller and DSP consumer see the slave view.
interface adc_frame_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 8
) ();
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);

  logic               conv_req;
  logic [1:0]         conv_ch;
  logic               conv_done;
  logic signed [10:0] conv_data;

  logic               frame_valid;
  logic               frame_ready;
  logic [43:0]        frame_data;
  logic [3:0]         frame_mask;
  logic [LevelW-1:0]  fifo_level;

  modport master (
    output conv_req,
    output conv_ch,
    input  conv_done,
    input  conv_data,
    output frame_valid,
    input  frame_ready,
    output frame_data,
    output frame_mask,
    output fifo_level
  );

  modport slave (
    input  conv_req,
    input  conv_ch,
    output conv_done,
    output conv_data,
    input  frame_valid,
    output frame_ready,
    input  frame_data,
    input  frame_mask,
    input  fifo_level
  );
endinterface

// File: rtl/adc_frame_scheduler.sv
// Periodic 4-channel ADC acquisition scheduler packing samples into frames behind a FWFT FIFO.
// Optional conversion watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_frame_scheduler #(
  parameter int unsigned SAMPLE_DIV = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                   clk_clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [3:0]             ch_mask,
  input  logic                   status_clr,
  output logic                   overflow,
  output logic                   overrun,
  output logic                   timeout,
  adc_frame_scheduler_if.master  bus
);

  localparam int unsigned TimerW = $clog2(SAMPLE_DIV);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TimerW-1:0] TimerReload = TimerW'(SAMPLE_DIV - 1);

  if (SAMPLE_DIV < 16 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1)
  begin : g_bad_params
    $error("adc_frame_scheduler: illegal parameter set");
  end

  typedef enum logic [2:0] {StIdle, StReq, StWait, StNext, StCommit} state_e;

  // Returns {found, ch}: lowest set channel of m at or above from.
  function automatic logic [2:0] first_set(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int c = 3; c >= 0; c--) begin
      if (m[c] && (c >= int'(from))) r = {1'b1, 2'(c)};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Tick timer
  // ---------------------------------------------------------------------------
  logic [TimerW-1:0] timer_q;
  logic              tick;

  assign tick = run && (timer_q == '0);

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      timer_q <= TimerReload;
    end else if (!run || timer_q == '0) begin
      timer_q <= TimerReload;
    end else begin
      timer_q <= timer_q - TimerW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Acquisition FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  cur_ch_q, cur_ch_d;
  logic [3:0]  mask_q, mask_d;
  logic [43:0] slots_q, slots_d;
  logic [2:0]  nxt;
  logic        push;
  logic        wd_expire;

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cur_ch_q <= 2'd0;
      mask_q   <= 4'd0;
      slots_q  <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
      mask_q   <= mask_d;
      slots_q  <= slots_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    mask_d   = mask_q;
    slots_d  = slots_q;
    nxt      = 3'b000;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          mask_d = ch_mask;
          nxt    = first_set(ch_mask, 3'd0);
          if (nxt[2]) begin
            state_d  = StReq;
            cur_ch_d = nxt[1:0];
          end
        end
      end
      StReq: state_d = StWait;
      StWait: begin
        if (bus.conv_done || wd_expire) begin
          slots_d[int'(cur_ch_q) * 11 +: 11] = bus.conv_done ? bus.conv_data : 11'd0;
          state_d = StNext;
        end
      end
      StNext: begin
        nxt = first_set(mask_q, {1'b0, cur_ch_q} + 3'd1);
        if (nxt[2]) begin
          state_d  = StReq;
          cur_ch_d = nxt[1:0];
        end else begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        push    = 1'b1;
        slots_d = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.conv_req = (state_q == StReq) || (state_q == StWait);
  assign bus.conv_ch  = cur_ch_q;

  // ---------------------------------------------------------------------------
  // Conversion watchdog
  // ---------------------------------------------------------------------------
`ifdef ADC_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q;
  logic           timeout_q;

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      wd_q <= '0;
    end else if (state_q == StWait) begin
      wd_q <= wd_q + WdW'(1);
    end else begin
      wd_q <= '0;
    end
  end

  // wd_q is 0 on the first WAIT cycle, so expiry lands on the TIMEOUT-th one.
  assign wd_expire = (state_q == StWait) && !bus.conv_done && (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (wd_expire) begin
      timeout_q <= 1'b1;
    end else if (status_clr) begin
      timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Frame FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [47:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LevelW-1:0] count_q;
  logic              full, empty, pop, push_ok;
  logic [47:0]       head;

  assign full    = (count_q == LevelW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty && bus.frame_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {mask_q, slots_q};
  end

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + LevelW'(push_ok) - LevelW'(pop);
    end
  end

  // Outputs forced to zero when empty so stale memory never shows after reset.
  assign head            = mem_q[rd_ptr_q];
  assign bus.frame_valid = !empty;
  assign bus.frame_data  = empty ? 44'd0 : head[43:0];
  assign bus.frame_mask  = empty ? 4'd0 : head[47:44];
  assign bus.fifo_level  = count_q;

  // ---------------------------------------------------------------------------
  // Sticky status
  // ---------------------------------------------------------------------------
  logic overflow_q, overrun_q;
  logic overflow_set, overrun_set;

  assign overflow_set = push && full && !pop;
  assign overrun_set  = tick && (state_q != StIdle);

  always_ff @(posedge clk_clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (overflow_set)    overflow_q <= 1'b1;
      else if (status_clr) overflow_q <= 1'b0;
      if (overrun_set)     overrun_q <= 1'b1;
      else if (status_clr) overrun_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Self-checking bench for adc_frame_scheduler: behavioural ADC responder plus frame model.
module tb_adc_frame_scheduler;

  logic       clk;
  logic       reset;
  logic       run;
  logic [3:0] ch_mask;
  logic       status_clr;
  logic       overflow, overrun, timeout;

  adc_frame_scheduler_if #(.FIFO_DEPTH(4)) bus ();

  adc_frame_scheduler #(
    .SAMPLE_DIV(32),
    .FIFO_DEPTH(4),
    .TIMEOUT   (8)
  ) dut (
    .clk_clk   (clk),
    .reset     (reset),
    .run       (run),
    .ch_mask   (ch_mask),
    .status_clr(status_clr),
    .overflow  (overflow),
    .overrun   (overrun),
    .timeout   (timeout),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Responder knobs and sample table (written by the main sequence only).
  logic [10:0] data_tbl [16][4];
  int          resp_delay = 3;
  bit          resp_mute1 = 1'b0;
  int          top_ch     = 3;

  // Responder-owned observation state.
  int frames_done = 0;
  int req_log[$];
  int start_q[$];
  int cyc = 0;

  // Behavioural ADC: answers each request resp_delay cycles later with a table sample.
  initial begin : responder
    int cnt;
    bit prev_req;
    cnt = 0;
    prev_req = 1'b0;
    bus.conv_done = 1'b0;
    bus.conv_data = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (bus.conv_req && !prev_req) begin
        req_log.push_back(int'(bus.conv_ch));
        if (bus.conv_ch == 2'd0) start_q.push_back(cyc);
      end
      prev_req = bus.conv_req;
      if (bus.conv_done) begin
        bus.conv_done = 1'b0;
        cnt = 0;
      end else if (bus.conv_req) begin
        cnt++;
        if (cnt >= resp_delay && !(resp_mute1 && bus.conv_ch == 2'd1)) begin
          bus.conv_done = 1'b1;
          bus.conv_data = data_tbl[frames_done % 16][bus.conv_ch];
          if (int'(bus.conv_ch) == top_ch) frames_done++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin : global_watchdog
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Expected {mask, ch3..ch0}: enabled channels carry the sample the ADC returned.
  function automatic logic [47:0] model_frame(input logic [3:0] m, input int row);
    logic [43:0] d;
    d = '0;
    for (int c = 0; c < 4; c++) begin
      if (m[c] && !(resp_mute1 && c == 1)) d[c*11 +: 11] = data_tbl[row % 16][c];
    end
    return {m, d};
  endfunction

  function automatic int highest(input logic [3:0] m);
    int h;
    h = 0;
    for (int c = 0; c < 4; c++) if (m[c]) h = c;
    return h;
  endfunction

  task automatic randomize_table();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 4; c++) data_tbl[r][c] = 11'($urandom);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_done < n && k < budget) begin
      step();
      k++;
    end
    check("wait_frames", 64'(frames_done >= n), 64'd1);
  endtask

  task automatic pop_check(input string tag, input logic [3:0] m, input int row);
    check({tag, "_valid"}, 64'(bus.frame_valid), 64'd1);
    check({tag, "_frame"}, 64'({bus.frame_mask, bus.frame_data}), 64'(model_frame(m, row)));
    bus.frame_ready = 1'b1;
    step();
    bus.frame_ready = 1'b0;
  endtask

  int         fb, lb, sb, k;
  logic [3:0] m;

  initial begin : main
    reset = 1'b1;
    run = 1'b0;
    ch_mask = 4'd0;
    status_clr = 1'b0;
    bus.frame_ready = 1'b0;
    randomize_table();
    repeat (3) step();
    reset = 1'b0;

    check("rst_conv_req", 64'(bus.conv_req), 64'd0);
    check("rst_conv_ch", 64'(bus.conv_ch), 64'd0);
    check("rst_valid", 64'(bus.frame_valid), 64'd0);
    check("rst_data", 64'(bus.frame_data), 64'd0);
    check("rst_mask", 64'(bus.frame_mask), 64'd0);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);

    // Basic: all channels, fixed samples, two frames.
    fb = frames_done; lb = req_log.size(); sb = start_q.size();
    for (int i = 0; i < 2; i++) begin
      data_tbl[(fb + i) % 16][0] = 11'h005;
      data_tbl[(fb + i) % 16][1] = 11'h7FF;
      data_tbl[(fb + i) % 16][2] = 11'h400;
      data_tbl[(fb + i) % 16][3] = 11'h123;
    end
    ch_mask = 4'hF; top_ch = 3; run = 1'b1;
    wait_frames(fb + 2, 200);
    repeat (4) step();
    run = 1'b0;
    check("basic_req_count", 64'(req_log.size() - lb), 64'd8);
    for (int i = 0; i < 8; i++) check("basic_req_ch", 64'(req_log[lb + i]), 64'(i % 4));
    check("basic_period", 64'(start_q[sb + 1] - start_q[sb]), 64'd32);
    check("basic_level", 64'(bus.fifo_level), 64'd2);
    check("basic_overrun", 64'(overrun), 64'd0);
    check("basic_literal", 64'({bus.frame_mask, bus.frame_data}),
          64'({4'hF, 11'h123, 11'h400, 11'h7FF, 11'h005}));
    pop_check("basic0", 4'hF, fb);
    pop_check("basic1", 4'hF, fb + 1);
    check("basic_empty", 64'(bus.frame_valid), 64'd0);

    // Sparse mask 1010.
    randomize_table();
    fb = frames_done; lb = req_log.size();
    ch_mask = 4'b1010; top_ch = 3; run = 1'b1;
    wait_frames(fb + 1, 200);
    repeat (4) step();
    run = 1'b0;
    check("sparse_req_count", 64'(req_log.size() - lb), 64'd2);
    check("sparse_req0", 64'(req_log[lb]), 64'd1);
    check("sparse_req1", 64'(req_log[lb + 1]), 64'd3);
    pop_check("sparse", 4'b1010, fb);

    // Zero mask: ticks occur but nothing is requested or committed.
    lb = req_log.size();
    ch_mask = 4'd0; run = 1'b1;
    repeat (100) step();
    run = 1'b0;
    check("zero_req_count", 64'(req_log.size() - lb), 64'd0);
    check("zero_level", 64'(bus.fifo_level), 64'd0);
    check("zero_overrun", 64'(overrun), 64'd0);

    // Backpressure: random nonzero mask, six frames into a depth-4 FIFO.
    randomize_table();
    fb = frames_done;
    m = 4'($urandom_range(1, 15));
    ch_mask = m; top_ch = highest(m); run = 1'b1;
    wait_frames(fb + 5, 400);
    repeat (4) step();
    check("bp_level5", 64'(bus.fifo_level), 64'd4);
    check("bp_overflow5", 64'(overflow), 64'd1);
    wait_frames(fb + 6, 100);
    repeat (4) step();
    run = 1'b0;
    check("bp_level6", 64'(bus.fifo_level), 64'd4);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("bp_overflow_clr", 64'(overflow), 64'd0);
    for (int i = 0; i < 4; i++) pop_check("bp", m, fb + i);
    check("bp_empty", 64'(bus.frame_valid), 64'd0);

    // Overrun: slow ADC makes each frame outlast the tick period.
    randomize_table();
    fb = frames_done;
    resp_delay = 10; ch_mask = 4'hF; top_ch = 3; run = 1'b1;
    wait_frames(fb + 2, 400);
    repeat (4) step();
    run = 1'b0;
    resp_delay = 3;
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_level", 64'(bus.fifo_level), 64'd2);
    pop_check("ovr0", 4'hF, fb);
    pop_check("ovr1", 4'hF, fb + 1);
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);

    // Reset while waiting on ch2 of the second frame.
    randomize_table();
    fb = frames_done;
    ch_mask = 4'hF; top_ch = 3; run = 1'b1;
    wait_frames(fb + 1, 200);
    k = 0;
    while (!(bus.conv_req && bus.conv_ch == 2'd2) && k < 200) begin
      step();
      k++;
    end
    check("rstm_reach_ch2", 64'(bus.conv_req && bus.conv_ch == 2'd2), 64'd1);
    check("rstm_pre_level", 64'(bus.fifo_level), 64'd1);
    step();
    reset = 1'b1;
    step();
    check("rstm_conv_req", 64'(bus.conv_req), 64'd0);
    check("rstm_level", 64'(bus.fifo_level), 64'd0);
    check("rstm_valid", 64'(bus.frame_valid), 64'd0);
    reset = 1'b0;
    fb = frames_done; lb = req_log.size();
    wait_frames(fb + 1, 200);
    repeat (4) step();
    run = 1'b0;
    check("rstm_first_ch", 64'(req_log[lb]), 64'd0);
    pop_check("rstm_frame", 4'hF, fb);

`ifdef ADC_SCHED_TIMEOUT_EN
    // ch1 is never answered; the watchdog must fill it with zero.
    randomize_table();
    fb = frames_done;
    resp_mute1 = 1'b1; ch_mask = 4'hF; top_ch = 3; run = 1'b1;
    check("to_pre", 64'(timeout), 64'd0);
    wait_frames(fb + 1, 300);
    repeat (4) step();
    run = 1'b0;
    check("to_flag", 64'(timeout), 64'd1);
    pop_check("to_frame", 4'hF, fb);
    resp_mute1 = 1'b0;
`else
    check("timeout_tied", 64'(timeout), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_scheduler.md
# adc_frame_scheduler

Schedules periodic multi-channel acquisitions on the 4-channel serial ADC controller and packs the results into frames. Raises a conversion request per enabled channel at a fixed sample rate and collects the 11-bit signed samples. Buffers completed frames in a small FIFO for the downstream localisation/DSP stage. Sits between the ADC control block and the signal-processing pipeline.

## Interface
- SAMPLE_DIV, 256: clock cycles between frame starts; must be ≥ 16.
- FIFO_DEPTH, 8: frame FIFO depth; power of two, ≥ 2.
- TIMEOUT, 64: cycles to wait for `conv_done`; used only with `ADC_SCHED_TIMEOUT_EN`.
- clk_clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  level; enables frame ticks.
- ch_mask  in  4  channel enable; latched at each frame start.
- conv_req  out  1  level request to the ADC controller; held until done.
- conv_ch  out  2  channel being converted; stable while `conv_req` = 1.
- conv_done  in  1  one-cycle pulse; sample is valid on `conv_data` in the same cycle.
- conv_data  in  11  signed sample.
- frame_valid  out  1  FIFO not empty.
- frame_ready  in  1  downstream accept.
- frame_data  out  44  {ch3,ch2,ch1,ch0}, 11 bits each; masked-off channels read 0.
- frame_mask  out  4  mask latched for the head frame.
- fifo_level  out  clog2(FIFO_DEPTH+1)  occupancy.
- overflow  out  1  sticky: a frame was dropped because the FIFO was full.
- overrun  out  1  sticky: a tick arrived while a frame was still in progress.
- timeout  out  1  sticky: a channel timed out (tied 0 without the macro).
- status_clr  in  1  clears all three sticky flags; a set event in the same cycle wins.

## Operation
- Tick timer:
  - Free-runs while `run` = 1, counting down from SAMPLE_DIV-1.
  - A tick is produced when the count is 0; the counter then reloads.
  - With `run` = 0 the timer is held at SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, latch `ch_mask`. If the latched mask is 0, stay in IDLE. Otherwise go to REQ with the lowest set channel selected.
  - REQ: `conv_req` = 1, `conv_ch` = current channel. Go to WAIT.
  - WAIT: hold `conv_req`. On `conv_done`, store `conv_data` into the current channel's slot. Go to NEXT.
  - NEXT: `conv_req` = 0. If a higher set channel remains, go to REQ with that channel; otherwise go to COMMIT.
  - COMMIT: push {slots, mask} into the FIFO. Zero the slots. Go to IDLE.
- `conv_done` is ignored outside WAIT.
- Channel order is always ascending, skipping masked-off channels.
- A tick while not in IDLE sets `overrun`; that tick is discarded and there is no catch-up.
- Deasserting `run` mid-frame has no effect on the current frame: it completes and is committed. No new ticks follow.
- FIFO behaviour:
  - First-word fall-through; pop occurs on `frame_valid && frame_ready`.
  - A push when full and not popping in the same cycle is dropped and sets `overflow`. Push and pop in the same cycle while full are both accepted.
  - `frame_ready` while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - `conv_req` = 0, `conv_ch` = 0.
  - `frame_valid` = 0, `frame_data` = 0, `frame_mask` = 0, `fifo_level` = 0.
  - All sticky flags = 0.
  - FSM in IDLE; timer = SAMPLE_DIV-1.
- Reset mid-frame discards the partial frame and all FIFO contents. `conv_req` is low from the first cycle after reset is sampled.

## Timing
- Tick in cycle T: `conv_req` and `conv_ch` are registered high in cycle T+1.
- `conv_done` sampled in cycle D:
  - `conv_req` is low in D+1.
  - The next request rises in D+2, so there is at least one low cycle between channels.
- Last `conv_done` in cycle D: COMMIT in D+2, `frame_valid` high and `fifo_level` incremented in D+3.
- Pop in cycle P: the next frame, or `frame_valid` = 0, is visible in P+1.
- Sticky flags are set in the cycle after the causing event.

## Configuration
- `ADC_SCHED_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in WAIT.
  - After TIMEOUT cycles without `conv_done`, the current slot is written with 0 and `timeout` is set.
  - The FSM then proceeds to NEXT exactly as if `conv_done` had arrived.
- Not defined:
  - No watchdog logic; WAIT waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- Basic frame: SAMPLE_DIV=32, `ch_mask`=4'hF, model returns `conv_done` 3 cycles after each request with data ch0=0x005, ch1=0x7FF, ch2=0x400, ch3=0x123.
  - Requires `conv_ch` sequence 0,1,2,3.
  - Requires `frame_data` = {0x123,0x400,0x7FF,0x005] per slot order {ch3,ch2,ch1,ch0}, `frame_mask`=4'hF.
  - Requires consecutive frame starts 32 cycles apart.
- Sparse mask: `ch_mask`=4'b1010.
  - Requires only ch1 then ch3 to be requested; slots ch0 and ch2 = 0.
  - `ch_mask`=0 requires no `conv_req` and no frames.
- Backpressure: FIFO_DEPTH=4, `frame_ready`=0 for 6 frames.
  - Requires `fifo_level`=4 and `overflow`=1 after the 5th frame.
  - The first 4 frames pop intact in order.
  - `status_clr` returns `overflow` to 0.
- Overrun: SAMPLE_DIV=16, model delays `conv_done` 10 cycles, `ch_mask`=4'hF.
  - Requires `overrun`=1 and every committed frame complete.
- Reset mid-frame: assert `reset` during WAIT on ch2.
  - Requires `conv_req`=0, `fifo_level`=0 and `frame_valid`=0 the next cycle.
  - Requires the next frame to start at ch0.
- Timeout (macro on, TIMEOUT=8): model never answers ch1.
  - Requires `timeout`=1 after 8 WAIT cycles.
  - Requires slot ch1=0 and the frame still committed with ch2 and ch3 data.
